// File: rtl/axi4_pkg.sv
// AXI4 field widths and encodings shared by the DMA read and write paths.
// Pure definitions: no latency, no backpressure.
package axi4_pkg;

    localparam int BURST_BITS = 2;
    localparam int SIZE_BITS  = 3;
    localparam int RESP_BITS  = 2;

    typedef enum logic [BURST_BITS-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [RESP_BITS-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // SLVERR and DECERR both carry bit 1; EXOKAY counts as success.
    function automatic logic resp_is_error(input logic [RESP_BITS-1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/dmac_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; registered state, data visible the cycle after push.
// Push accepted when not full or when popping the same cycle; pop ignored when empty.
module dmac_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = CW'(wr_ptr - rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // When full, the write slot equals the head slot; the head is read before this edge lands.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmac_write_response.sv
// Matches AXI B responses to issued AW bursts in order and reports per-channel transfer completion one cycle after the last B.
// Backpressure: AW issue stalls when the tracker is full; bready drops while a final response would overwrite an unaccepted report.
module dmac_write_response
    import axi4_pkg::*;
#(
    parameter int  CHANNEL_COUNT   = 8,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int CH_WD           = $clog2(CHANNEL_COUNT),
    localparam int CNT_WD          = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 aw_issue_valid,
    output logic                 aw_issue_ready,
    input  logic [CH_WD-1:0]     aw_issue_channel,
    input  logic                 aw_issue_last,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    input  logic [RESP_BITS-1:0] m_axi_bresp,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [CH_WD-1:0]     done_channel,
    output logic                 done_error,
    output logic [CNT_WD-1:0]    outstanding_count
);

    typedef struct packed {
        logic [CH_WD-1:0] channel;
        logic             last;
    } issue_t;

    issue_t             push_ent;
    issue_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               b_hs;
    logic               resp_err;
    logic [CHANNEL_COUNT-1:0] err;

    assign push_ent = '{channel: aw_issue_channel, last: aw_issue_last};

    dmac_sync_fifo #(
        .WIDTH ($bits(issue_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_issue_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aw_issue_valid),
        .push_data (push_ent),
        .pop       (b_hs),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_count)
    );

    // A final response may only complete when the report slot is free or being freed this cycle.
    assign m_axi_bready   = !fifo_empty && (!head.last || !done_valid || done_ready);
    assign b_hs           = m_axi_bvalid && m_axi_bready;
    assign aw_issue_ready = !fifo_full || b_hs;
    assign resp_err       = resp_is_error(m_axi_bresp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_valid   <= 1'b0;
            done_channel <= '0;
            done_error   <= 1'b0;
            err          <= '0;
        end else begin
            if (done_valid && done_ready) done_valid <= 1'b0;
            if (b_hs) begin
                if (head.last) begin
                    done_valid         <= 1'b1;
                    done_channel       <= head.channel;
                    done_error         <= err[head.channel] | resp_err;
                    err[head.channel]  <= 1'b0;
                end else if (resp_err) begin
                    err[head.channel]  <= 1'b1;
                end
            end
        end
    end

    a_issue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        aw_issue_valid |-> aw_issue_ready);

    a_bvalid_empty: assert property (@(posedge clk) disable iff (!rst_n)
        m_axi_bvalid |-> !fifo_empty);

endmodule
